// File: rtl/filtez_if.sv
// Call handshake plus coefficient/history RAM read ports for the zero-section predictor filter.
// The slave modport is the filter; the master modport is the caller and the RAM side.
interface filtez_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic              ap_start;
  logic              ap_done;
  logic              ap_idle;
  logic              ap_ready;
  logic [DATA_W-1:0] ap_return;
  logic [ADDR_W-1:0] bli_address0;
  logic              bli_ce0;
  logic [DATA_W-1:0] bli_q0;
  logic [ADDR_W-1:0] dlti_address0;
  logic              dlti_ce0;
  logic [DATA_W-1:0] dlti_q0;

  modport master (
    output ap_start, bli_q0, dlti_q0,
    input  ap_done, ap_idle, ap_ready, ap_return,
    input  bli_address0, bli_ce0, dlti_address0, dlti_ce0
  );

  modport slave (
    input  ap_start, bli_q0, dlti_q0,
    output ap_done, ap_idle, ap_ready, ap_return,
    output bli_address0, bli_ce0, dlti_address0, dlti_ce0
  );
endinterface

// File: rtl/filtez.sv
// Zero-section predictor: sums six signed bli*dlti products into a 64-bit wrapping
// accumulator and returns acc >>> SHIFT truncated to DATA_W, one tap every two cycles.
module filtez #(
  parameter int N_TAPS = 6,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  parameter int SHIFT  = 14
) (
  input  logic     ap_clk,
  input  logic     ap_rst_n,
  filtez_if.slave  bus
);
  localparam int ACC_W = 2 * DATA_W;
  localparam logic [ADDR_W:0] LAST_I = (ADDR_W + 1)'(N_TAPS);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_READ = 4'b0010,
    S_MAC  = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W:0]          i_q, i_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] ret_q, ret_d;

  logic signed [DATA_W-1:0] bli_s, dlti_s;
  logic signed [ACC_W-1:0]  bli_x, dlti_x, prod;
  logic                     ce;
  logic [ADDR_W-1:0]        addr;
  logic                     in_idle;

  // Arithmetic shift then truncate: keeps acc[SHIFT+DATA_W-1:SHIFT].
  function automatic logic signed [DATA_W-1:0] scale_acc(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    sh = a >>> SHIFT;
    return sh[DATA_W-1:0];
  endfunction

  // Operands are sign-extended first so the 64-bit product is exact, then wraps in the sum.
  assign bli_s  = bus.bli_q0;
  assign dlti_s = bus.dlti_q0;
  assign bli_x  = ACC_W'(bli_s);
  assign dlti_x = ACC_W'(dlti_s);
  assign prod   = bli_x * dlti_x;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      acc_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    acc_d   = acc_q;
    ret_d   = ret_q;
    ce      = 1'b0;
    addr    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.ap_start) begin
          acc_d   = '0;
          i_d     = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (i_q == LAST_I) begin
          state_d = S_DONE;
        end else begin
          ce      = 1'b1;
          addr    = i_q[ADDR_W-1:0];
          i_d     = i_q + 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d   = acc_q + prod;
        state_d = S_READ;
      end
      S_DONE: begin
        ret_d   = scale_acc(acc_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_idle = (state_q == S_IDLE);

  assign bus.ap_idle       = in_idle & ~bus.ap_start;
  assign bus.ap_done       = (state_q == S_DONE) | (in_idle & ~bus.ap_start);
  assign bus.ap_ready      = (state_q == S_DONE);
  assign bus.ap_return     = ret_q;
  assign bus.bli_ce0       = ce;
  assign bus.dlti_ce0      = ce;
  assign bus.bli_address0  = addr;
  assign bus.dlti_address0 = addr;
endmodule

// File: tb/tb_filtez.sv
// Bench for filtez: RAM models with 1-cycle read latency, directed and random calls
// compared against a longint sum-of-products reference.
module tb_filtez;
  localparam int N_TAPS = 6;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  int   n_vec = 0;
  int   n_bad = 0;
  int   bli_mem[8];
  int   dlti_mem[8];
  int   exp_a, exp_b;

  filtez_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  filtez #(.N_TAPS(N_TAPS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SHIFT(14)) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus     (bus.slave)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) begin
    if (bus.bli_ce0)  bus.bli_q0  <= bli_mem[bus.bli_address0];
    if (bus.dlti_ce0) bus.dlti_q0 <= dlti_mem[bus.dlti_address0];
  end

  function automatic int model();
    longint acc = 0;
    for (int t = 0; t < N_TAPS; t++)
      acc += longint'(bli_mem[t]) * longint'(dlti_mem[t]);
    return int'(acc >>> 14);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mems();
    for (int t = 0; t < 8; t++) begin
      bli_mem[t]  = 0;
      dlti_mem[t] = 0;
    end
  endtask

  task automatic random_mems();
    for (int t = 0; t < 8; t++) begin
      bli_mem[t]  = int'($urandom);
      dlti_mem[t] = int'($urandom);
    end
  endtask

  task automatic start_call();
    @(posedge ap_clk); #1;
    bus.ap_start = 1'b1;
    @(negedge ap_clk);
    check("start_idle", 32'(bus.ap_idle), 32'd0);
    check("start_done", 32'(bus.ap_done), 32'd0);
  endtask

  // Cycle k after the start cycle T; tap k/2 is read on odd k up to 11, done at 14.
  task automatic do_call(input string name, input logic [31:0] exp_ret, input bit keep_start);
    bit rd;
    for (int k = 1; k <= 14; k++) begin
      @(posedge ap_clk); #1;
      if (!keep_start) bus.ap_start = 1'b0;
      @(negedge ap_clk);
      rd = (k % 2 == 1) && (k <= 11);
      check($sformatf("%s_bce_t%0d", name, k), 32'(bus.bli_ce0), 32'(rd));
      check($sformatf("%s_dce_t%0d", name, k), 32'(bus.dlti_ce0), 32'(rd));
      if (rd) begin
        check($sformatf("%s_badr_t%0d", name, k), 32'(bus.bli_address0), 32'((k - 1) / 2));
        check($sformatf("%s_dadr_t%0d", name, k), 32'(bus.dlti_address0), 32'((k - 1) / 2));
      end
      check($sformatf("%s_done_t%0d", name, k), 32'(bus.ap_done), 32'(k == 14));
      check($sformatf("%s_ready_t%0d", name, k), 32'(bus.ap_ready), 32'(k == 14));
      check($sformatf("%s_idle_t%0d", name, k), 32'(bus.ap_idle), 32'd0);
    end
    @(negedge ap_clk);
    check({name, "_ret"}, bus.ap_return, exp_ret);
    check({name, "_done_after"}, 32'(bus.ap_done), 32'(!bus.ap_start));
    check({name, "_idle_after"}, 32'(bus.ap_idle), 32'(!bus.ap_start));
    check({name, "_ready_after"}, 32'(bus.ap_ready), 32'd0);
  endtask

  initial begin
    ap_rst_n     = 1'b0;
    bus.ap_start = 1'b0;
    clear_mems();
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_ret", bus.ap_return, 32'd0);
    check("rst_idle", 32'(bus.ap_idle), 32'd1);
    check("rst_done", 32'(bus.ap_done), 32'd1);
    check("rst_ready", 32'(bus.ap_ready), 32'd0);
    check("rst_bce", 32'(bus.bli_ce0), 32'd0);
    check("rst_dce", 32'(bus.dlti_ce0), 32'd0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;

    for (int t = 0; t < N_TAPS; t++) begin
      bli_mem[t]  = 16384;
      dlti_mem[t] = t + 1;
    end
    start_call();
    do_call("basic", 32'd21, 1'b0);

    clear_mems();
    bli_mem[0] = -16384; dlti_mem[0] = 1;
    start_call();
    do_call("sign_a", 32'hFFFF_FFFF, 1'b0);

    bli_mem[0] = -1;
    start_call();
    do_call("sign_b", 32'hFFFF_FFFF, 1'b0);

    bli_mem[0] = 32'h0001_0000; dlti_mem[0] = 32'h0001_0000;
    start_call();
    do_call("width", 32'd262144, 1'b0);

    bli_mem[0] = 32'h4000_0000; dlti_mem[0] = 32'h4000_0000;
    start_call();
    do_call("trunc", 32'd0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      random_mems();
      exp_a = model();
      start_call();
      do_call($sformatf("rand%0d", r), 32'(exp_a), 1'b0);
    end

    random_mems();
    exp_a = model();
    start_call();
    do_call("b2b_1", 32'(exp_a), 1'b1);
    random_mems();
    exp_b = model();
    do_call("b2b_2", 32'(exp_b), 1'b0);

    random_mems();
    exp_a = model();
    start_call();
    for (int k = 1; k <= 8; k++) begin
      @(posedge ap_clk); #1;
      bus.ap_start = 1'b0;
    end
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_idle", 32'(bus.ap_idle), 32'd1);
    check("mid_rst_done", 32'(bus.ap_done), 32'd1);
    check("mid_rst_ready", 32'(bus.ap_ready), 32'd0);
    check("mid_rst_ret", bus.ap_return, 32'd0);
    check("mid_rst_bce", 32'(bus.bli_ce0), 32'd0);
    check("mid_rst_dce", 32'(bus.dlti_ce0), 32'd0);
    @(negedge ap_clk);
    check("mid_rst_hold_ret", bus.ap_return, 32'd0);
    check("mid_rst_hold_idle", 32'(bus.ap_idle), 32'd1);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    start_call();
    do_call("after_rst", 32'(exp_a), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
